// File: rtl/credit_bcd_driver.sv
// credit_bcd_driver: iterative double-dabble binary-to-BCD converter feeding seven_seg digit drivers
// Ports: clk, rst_n (sync, active-low); bin_in + start request a conversion;
//        busy is high while shifting, done pulses once when dig_out/dig_en update;
//        dig_out holds one BCD nibble per digit (units in [3:0]), dig_en holds per-digit enables.
module credit_bcd_driver #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    bin_in,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] dig_out,
  output logic [DIGITS-1:0]   dig_en
);
  localparam int CW = $clog2(WIDTH + 1);
  function automatic logic [127:0] pow10(int n);
    logic [127:0] p;
    p = 128'd1;
    for (int k = 0; k < n; k++) p = p * 128'd10;
    return p;
  endfunction
  // DIGITS must be able to represent the largest WIDTH-bit value
  if (pow10(DIGITS) <= ((128'd1 << WIDTH) - 128'd1)) begin : g_bad_params
    $error("credit_bcd_driver: DIGITS too small for WIDTH");
  end
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, stateNext;
  logic [WIDTH-1:0]    shiftReg;
  logic [4*DIGITS-1:0] bcdAcc, bcdAdj, bcdNext;
  logic [DIGITS-1:0]   enNext;
  logic [CW-1:0]       cnt;
  logic                lastShift;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    // add-3 stays inside the nibble; no carry into the next digit
    assign bcdAdj[4*i+:4] = bcdAcc[4*i+:4] >= 4'd5 ? bcdAcc[4*i+:4] + 4'd3 : bcdAcc[4*i+:4];
    // a digit shows if it is the units digit or any digit at or above it is nonzero
    assign enNext[i] = BLANK_LZ == 0 || i == 0 || |bcdNext[4*DIGITS-1:4*i];
  end
  assign bcdNext   = {bcdAdj[4*DIGITS-2:0], shiftReg[WIDTH-1]};
  assign lastShift = cnt == CW'(WIDTH - 1);
  always_comb begin
    stateNext = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE:    stateNext = start ? SHIFT : IDLE;
      SHIFT: begin
        busy = 1'b1;
        stateNext = lastShift ? DONE : SHIFT;
      end
      DONE: begin
        done = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= stateNext;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shiftReg <= '0;
      bcdAcc   <= '0;
      cnt      <= '0;
      dig_out  <= '0;
      dig_en   <= DIGITS'(1);
    end else if (state == IDLE && start) begin
      shiftReg <= bin_in;
      bcdAcc   <= '0;
      cnt      <= '0;
    end else if (state == SHIFT) begin
      shiftReg <= shiftReg << 1;
      bcdAcc   <= bcdNext;
      cnt      <= cnt + 1'b1;
      // result registers update only on the edge that enters DONE
      if (lastShift) begin
        dig_out <= bcdNext;
        dig_en  <= enNext;
      end
    end
  end
endmodule
